// File: rtl/hazard_ctrl_n.sv
// hazard_ctrl_n: pipeline hazard controller with forwarding, load-use stall, stall/flush chain and trap/IRQ redirect sequencing
// Optional feature macro: HAZARD_CTRL_IRQ_EN compiles in the interrupt drain FSM, epc and cause latch.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   ex_*                         ID/EX sources, validity, branch request and target
//   st_*                         per post-EX register rd/flags/data/stall request (index 0 = EX/MEM1)
//   if_id_*, fetch_pc_i          PCs used to form the interrupt return address
//   trap_*                       trap/MRET from the last register
//   irq_*                        pending {mei, mti, msi} and global enable
//   fwd_*                        forwarding enables and data for rs1/rs2
//   stall_o, flush_o             per register: 0 IF/ID, 1 ID/EX, j+2 post-EX j
//   new_pc_*, pc_sel_o           fetch redirect (0 JUMP, 1 TRAP, 2 MEPC)
//   is_trap_o, csr_mret_o        CSR side-effect strobes
//   mcause_o, exc_pc_o           {irq, code} and mepc value on interrupt entry
//   ldu_stall_cnt_o              saturating load-use stall cycle count
module hazard_ctrl_n #(
   parameter int NSTG     = 3,
   parameter int LOAD_STG = 2,
   parameter int XLEN     = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [4:0]           ex_rs1_addr_i,
   input  logic [4:0]           ex_rs2_addr_i,
   input  logic                 ex_valid_i,
   input  logic [5*NSTG-1:0]    st_rd_addr_i,
   input  logic [NSTG-1:0]      st_write_rd_i,
   input  logic [NSTG-1:0]      st_is_load_i,
   input  logic [NSTG-1:0]      st_valid_i,
   input  logic [XLEN*NSTG-1:0] st_fwd_data_i,
   input  logic [NSTG-1:0]      st_stall_req_i,
   input  logic                 if_id_valid_i,
   input  logic [XLEN-1:0]      if_id_pc_i,
   input  logic [XLEN-1:0]      fetch_pc_i,
   input  logic                 ex_new_pc_en_i,
   input  logic [XLEN-1:0]      ex_new_pc_i,
   input  logic                 trap_i,
   input  logic                 trap_mret_i,
   input  logic [3:0]           trap_code_i,
   input  logic [2:0]           irq_pending_i,
   input  logic                 irq_global_en_i,
   output logic                 fwd_rs1_en_o,
   output logic                 fwd_rs2_en_o,
   output logic [XLEN-1:0]      fwd_rs1_data_o,
   output logic [XLEN-1:0]      fwd_rs2_data_o,
   output logic [NSTG+1:0]      stall_o,
   output logic [NSTG+1:0]      flush_o,
   output logic                 new_pc_en_o,
   output logic [1:0]           pc_sel_o,
   output logic [XLEN-1:0]      new_pc_o,
   output logic                 is_trap_o,
   output logic                 csr_mret_o,
   output logic [4:0]           mcause_o,
   output logic [XLEN-1:0]      exc_pc_o,
   output logic [31:0]          ldu_stall_cnt_o
);
   localparam logic [1:0] PC_JUMP = 2'd0;
   localparam logic [1:0] PC_TRAP = 2'd1;
   localparam logic [1:0] PC_MEPC = 2'd2;

   logic            w_haz1, w_haz2, w_hazard;
   logic            w_drain, w_take, w_branch;
   logic [4:0]      w_take_cause;
   logic [NSTG+1:0] w_stall, w_flush;
   logic [31:0]     r_cnt;

   // Walk from the oldest stage down so the youngest match overrides.
   // Hazard looks at the youngest writer regardless of its valid flag;
   // forwarding only takes eligible stages.
   always_comb begin
      fwd_rs1_en_o   = 1'b0;
      fwd_rs2_en_o   = 1'b0;
      fwd_rs1_data_o = '0;
      fwd_rs2_data_o = '0;
      w_haz1         = 1'b0;
      w_haz2         = 1'b0;
      for (int k = NSTG-1; k >= 0; k--) begin
         if (st_rd_addr_i[5*k +: 5] != 5'd0 && st_write_rd_i[k]) begin
            if (st_rd_addr_i[5*k +: 5] == ex_rs1_addr_i) begin
               w_haz1 = st_is_load_i[k] && (k < LOAD_STG);
               if (st_valid_i[k] && (!st_is_load_i[k] || k >= LOAD_STG)) begin
                  fwd_rs1_en_o   = 1'b1;
                  fwd_rs1_data_o = st_fwd_data_i[XLEN*k +: XLEN];
               end
            end
            if (st_rd_addr_i[5*k +: 5] == ex_rs2_addr_i) begin
               w_haz2 = st_is_load_i[k] && (k < LOAD_STG);
               if (st_valid_i[k] && (!st_is_load_i[k] || k >= LOAD_STG)) begin
                  fwd_rs2_en_o   = 1'b1;
                  fwd_rs2_data_o = st_fwd_data_i[XLEN*k +: XLEN];
               end
            end
         end
      end
   end

   assign w_hazard = ex_valid_i & (w_haz1 | w_haz2);

   // A held stage freezes everything upstream of it.
   always_comb begin
      w_stall = '0;
      for (int j = 0; j < NSTG; j++)
         w_stall[j+2] = |(st_stall_req_i >> j);
      w_stall[1] = w_hazard | w_stall[2];
      w_stall[0] = w_stall[1] | w_drain;
   end

   assign w_branch = ex_new_pc_en_i & ~w_stall[1];
   assign stall_o  = w_stall;
   assign flush_o  = w_flush;
   assign new_pc_o = ex_new_pc_i;

   always_comb begin
      w_flush     = '0;
      new_pc_en_o = 1'b0;
      pc_sel_o    = PC_JUMP;
      is_trap_o   = 1'b0;
      csr_mret_o  = 1'b0;
      mcause_o    = {1'b0, trap_code_i};
      // A bubble enters wherever a stalled register feeds a moving one.
      for (int j = 0; j <= NSTG; j++)
         w_flush[j+1] = w_stall[j] & ~w_stall[j+1];
      if (w_drain)
         w_flush[1] = 1'b1;
      if (trap_i) begin
         w_flush[NSTG:0] = '1;
         new_pc_en_o     = 1'b1;
         pc_sel_o        = trap_mret_i ? PC_MEPC : PC_TRAP;
         csr_mret_o      = trap_mret_i;
         is_trap_o       = ~trap_mret_i;
      end else if (w_take) begin
         w_flush[1:0] = '1;
         new_pc_en_o  = 1'b1;
         pc_sel_o     = PC_TRAP;
         is_trap_o    = 1'b1;
         mcause_o     = w_take_cause;
      end else if (w_branch && !w_drain) begin
         w_flush[1:0] = '1;
         new_pc_en_o  = 1'b1;
      end
      if (rst_i) begin
         new_pc_en_o = 1'b0;
         is_trap_o   = 1'b0;
         csr_mret_o  = 1'b0;
      end
   end

`ifdef HAZARD_CTRL_IRQ_EN
   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_TAKE} state_t;
   state_t          r_state, w_next;
   logic [XLEN-1:0] r_epc;
   logic [3:0]      r_code;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_RUN:   if (irq_global_en_i && |irq_pending_i) w_next = S_DRAIN;
         S_DRAIN: if (!ex_valid_i && !(|st_valid_i)) w_next = S_TAKE;
         default: w_next = S_RUN;
      endcase
      if (trap_i)
         w_next = S_RUN;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_RUN;
         r_epc   <= '0;
         r_code  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_RUN && w_next == S_DRAIN) begin
            r_epc  <= if_id_valid_i ? if_id_pc_i : fetch_pc_i;
            r_code <= irq_pending_i[2] ? 4'd11 : irq_pending_i[0] ? 4'd3 : 4'd7;
         end else if (w_drain && w_branch) begin
            // The branch target becomes the resume point instead of a redirect.
            r_epc <= ex_new_pc_i;
         end
      end
   end

   assign w_drain      = r_state == S_DRAIN;
   assign w_take       = r_state == S_TAKE;
   assign w_take_cause = {1'b1, r_code};
   assign exc_pc_o     = r_epc;
`else
   logic w_unused;
   assign w_unused     = ^{irq_pending_i, irq_global_en_i, if_id_valid_i, if_id_pc_i, fetch_pc_i};
   assign w_drain      = 1'b0;
   assign w_take       = 1'b0;
   assign w_take_cause = '0;
   assign exc_pc_o     = '0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_cnt <= '0;
      else if (w_hazard && !w_stall[2] && !(&r_cnt))
         r_cnt <= r_cnt + 32'd1;
   end

   assign ldu_stall_cnt_o = r_cnt;
endmodule

// File: tb/tb_hazard_ctrl_n.sv
// tb_hazard_ctrl_n: table-driven and sequence checks for hazard_ctrl_n
module tb_hazard_ctrl_n;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  rs1 = '0, rs2 = '0;
   logic        ev = 1'b0;
   logic [14:0] rd = '0;
   logic [2:0]  wr = '0, ld = '0, vld = '0, req = '0;
   logic [95:0] fdata = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
   logic        ifv = 1'b0;
   logic [31:0] ifpc = '0, fpc = 32'h44;
   logic        br = 1'b0;
   logic [31:0] brpc = '0;
   logic        trap = 1'b0, mret = 1'b0;
   logic [3:0]  tcode = '0;
   logic [2:0]  irq = '0;
   logic        gen = 1'b0;
   logic        f1e, f2e, npc, istrap, cmret;
   logic [31:0] f1d, f2d, npco, epc, cnt;
   logic [4:0]  stl, fl, mcause;
   logic [1:0]  psel;
   int          passed = 0, total = 0;

   always #5 clk = ~clk;

   hazard_ctrl_n dut (
      .clk_i(clk), .rst_i(rst),
      .ex_rs1_addr_i(rs1), .ex_rs2_addr_i(rs2), .ex_valid_i(ev),
      .st_rd_addr_i(rd), .st_write_rd_i(wr), .st_is_load_i(ld), .st_valid_i(vld),
      .st_fwd_data_i(fdata), .st_stall_req_i(req),
      .if_id_valid_i(ifv), .if_id_pc_i(ifpc), .fetch_pc_i(fpc),
      .ex_new_pc_en_i(br), .ex_new_pc_i(brpc),
      .trap_i(trap), .trap_mret_i(mret), .trap_code_i(tcode),
      .irq_pending_i(irq), .irq_global_en_i(gen),
      .fwd_rs1_en_o(f1e), .fwd_rs2_en_o(f2e), .fwd_rs1_data_o(f1d), .fwd_rs2_data_o(f2d),
      .stall_o(stl), .flush_o(fl),
      .new_pc_en_o(npc), .pc_sel_o(psel), .new_pc_o(npco),
      .is_trap_o(istrap), .csr_mret_o(cmret), .mcause_o(mcause), .exc_pc_o(epc),
      .ldu_stall_cnt_o(cnt)
   );

   typedef struct {
      logic [4:0]  rs1, rs2;
      logic        ev;
      logic [14:0] rd;
      logic [2:0]  wr, ld, vld, req;
      logic        br;
      logic        f1e;
      logic [31:0] f1d;
      logic        f2e;
      logic [31:0] f2d;
      logic [4:0]  stl, fl;
      logic        npc;
   } vec_t;

   vec_t vt[11];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else
         passed++;
   endtask

   task automatic drive(input vec_t v);
      rs1 = v.rs1; rs2 = v.rs2; ev = v.ev; rd = v.rd;
      wr = v.wr; ld = v.ld; vld = v.vld; req = v.req; br = v.br;
   endtask

   task automatic idle();
      rs1 = '0; rs2 = '0; ev = 1'b0; rd = '0; wr = '0; ld = '0; vld = '0; req = '0; br = 1'b0;
   endtask

   initial begin
      vt[0]  = '{5'd3, 5'd0, 1'b1, {5'd3, 5'd3, 5'd3}, 3'b111, 3'b000, 3'b111, 3'b000, 1'b0,
                 1'b1, 32'hAAAA0000, 1'b0, 32'h0, 5'b00000, 5'b00000, 1'b0};
      vt[1]  = '{5'd0, 5'd5, 1'b1, {10'd0, 5'd5}, 3'b001, 3'b001, 3'b001, 3'b000, 1'b0,
                 1'b0, 32'h0, 1'b0, 32'h0, 5'b00011, 5'b00100, 1'b0};
      vt[2]  = '{5'd5, 5'd0, 1'b1, {5'd5, 10'd0}, 3'b100, 3'b100, 3'b100, 3'b000, 1'b0,
                 1'b1, 32'hCCCC0002, 1'b0, 32'h0, 5'b00000, 5'b00000, 1'b0};
      vt[3]  = '{5'd0, 5'd5, 1'b1, {10'd0, 5'd5}, 3'b001, 3'b001, 3'b001, 3'b100, 1'b0,
                 1'b0, 32'h0, 1'b0, 32'h0, 5'b11111, 5'b00000, 1'b0};
      vt[4]  = '{5'd0, 5'd0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b010, 1'b0,
                 1'b0, 32'h0, 1'b0, 32'h0, 5'b01111, 5'b10000, 1'b0};
      vt[5]  = '{5'd0, 5'd0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1,
                 1'b0, 32'h0, 1'b0, 32'h0, 5'b00000, 5'b00011, 1'b1};
      vt[6]  = '{5'd0, 5'd5, 1'b1, {10'd0, 5'd5}, 3'b001, 3'b001, 3'b001, 3'b000, 1'b1,
                 1'b0, 32'h0, 1'b0, 32'h0, 5'b00011, 5'b00100, 1'b0};
      vt[7]  = '{5'd0, 5'd5, 1'b0, {10'd0, 5'd5}, 3'b001, 3'b001, 3'b001, 3'b000, 1'b0,
                 1'b0, 32'h0, 1'b0, 32'h0, 5'b00000, 5'b00000, 1'b0};
      vt[8]  = '{5'd5, 5'd5, 1'b1, {5'd0, 5'd5, 5'd5}, 3'b010, 3'b001, 3'b011, 3'b000, 1'b0,
                 1'b1, 32'hBBBB0001, 1'b1, 32'hBBBB0001, 5'b00000, 5'b00000, 1'b0};
      vt[9]  = '{5'd7, 5'd0, 1'b1, {5'd0, 5'd7, 5'd7}, 3'b011, 3'b000, 3'b010, 3'b000, 1'b0,
                 1'b1, 32'hBBBB0001, 1'b0, 32'h0, 5'b00000, 5'b00000, 1'b0};
      vt[10] = '{5'd9, 5'd9, 1'b1, {5'd0, 5'd9, 5'd0}, 3'b010, 3'b010, 3'b010, 3'b000, 1'b0,
                 1'b0, 32'h0, 1'b0, 32'h0, 5'b00011, 5'b00100, 1'b0};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         drive(vt[i]);
         #1;
         chk($sformatf("v%0d fwd1_en", i), 64'(f1e), 64'(vt[i].f1e));
         chk($sformatf("v%0d fwd1_data", i), 64'(f1d), 64'(vt[i].f1d));
         chk($sformatf("v%0d fwd2_en", i), 64'(f2e), 64'(vt[i].f2e));
         chk($sformatf("v%0d fwd2_data", i), 64'(f2d), 64'(vt[i].f2d));
         chk($sformatf("v%0d stall", i), 64'(stl), 64'(vt[i].stl));
         chk($sformatf("v%0d flush", i), 64'(fl), 64'(vt[i].fl));
         chk($sformatf("v%0d new_pc_en", i), 64'(npc), 64'(vt[i].npc));
      end

      // reset: redirect strobes forced low, counter cleared
      @(negedge clk);
      idle();
      rst = 1'b1; trap = 1'b1; mret = 1'b0;
      #1;
      chk("rst new_pc_en", 64'(npc), 64'd0);
      chk("rst is_trap", 64'(istrap), 64'd0);
      mret = 1'b1;
      #1;
      chk("rst csr_mret", 64'(cmret), 64'd0);
      @(negedge clk);
      trap = 1'b0; mret = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst counter", 64'(cnt), 64'd0);

      // trap and MRET
      trap = 1'b1; tcode = 4'h2;
      #1;
      chk("trap new_pc_en", 64'(npc), 64'd1);
      chk("trap pc_sel", 64'(psel), 64'd1);
      chk("trap is_trap", 64'(istrap), 64'd1);
      chk("trap mcause", 64'(mcause), 64'h02);
      chk("trap flush", 64'(fl), 64'b01111);
      mret = 1'b1;
      #1;
      chk("mret pc_sel", 64'(psel), 64'd2);
      chk("mret csr_mret", 64'(cmret), 64'd1);
      chk("mret is_trap", 64'(istrap), 64'd0);
      trap = 1'b0; mret = 1'b0;

      // load-use: two stall cycles then forward from stage 2
      @(negedge clk);
      drive(vt[1]);
      #1;
      chk("ldu c1 flush", 64'(fl), 64'b00100);
      @(negedge clk);
      #1;
      chk("ldu c2 stall", 64'(stl), 64'b00011);
      chk("ldu cnt after 1", 64'(cnt), 64'd1);
      @(negedge clk);
      rs1 = 5'd0; rs2 = 5'd5; rd = {5'd5, 10'd0}; wr = 3'b100; ld = 3'b100; vld = 3'b100;
      #1;
      chk("ldu fwd2_en", 64'(f2e), 64'd1);
      chk("ldu fwd2_data", 64'(f2d), 64'hCCCC0002);
      chk("ldu stall clear", 64'(stl), 64'd0);
      @(negedge clk);
      #1;
      chk("ldu cnt", 64'(cnt), 64'd2);
      drive(vt[3]);
      @(negedge clk);
      #1;
      chk("ldu cnt held by stall", 64'(cnt), 64'd2);
      idle();

`ifdef HAZARD_CTRL_IRQ_EN
      // mti, drain until empty, then take
      @(negedge clk);
      irq = 3'b010; gen = 1'b1; ifv = 1'b1; ifpc = 32'h80; ev = 1'b1; vld = 3'b001;
      @(negedge clk);
      #1;
      chk("drain stall0", 64'(stl[0]), 64'd1);
      chk("drain flush1", 64'(fl[1]), 64'd1);
      chk("drain no redirect", 64'(npc), 64'd0);
      @(negedge clk);
      ev = 1'b0; vld = 3'b000;
      #1;
      chk("drain held", 64'(stl[0]), 64'd1);
      @(negedge clk);
      #1;
      chk("take new_pc_en", 64'(npc), 64'd1);
      chk("take pc_sel", 64'(psel), 64'd1);
      chk("take is_trap", 64'(istrap), 64'd1);
      chk("take exc_pc", 64'(epc), 64'h80);
      chk("take mcause", 64'(mcause), 64'h17);
      irq = 3'b000;
      @(negedge clk);
      #1;
      chk("after take", 64'(npc), 64'd0);

      // branch during drain retargets epc
      irq = 3'b100; ifpc = 32'h80;
      @(negedge clk);
      ev = 1'b1; br = 1'b1; brpc = 32'h200;
      #1;
      chk("drain branch no redirect", 64'(npc), 64'd0);
      @(negedge clk);
      ev = 1'b0; br = 1'b0;
      @(negedge clk);
      #1;
      chk("br take exc_pc", 64'(epc), 64'h200);
      chk("br take mcause", 64'(mcause), 64'h1B);
      irq = 3'b000;

      // MRET trap in the take cycle wins
      @(negedge clk);
      irq = 3'b001;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("pre-mret take", 64'(istrap), 64'd1);
      trap = 1'b1; mret = 1'b1; irq = 3'b000;
      #1;
      chk("take+mret pc_sel", 64'(psel), 64'd2);
      chk("take+mret csr_mret", 64'(cmret), 64'd1);
      chk("take+mret is_trap", 64'(istrap), 64'd0);
      @(negedge clk);
      trap = 1'b0; mret = 1'b0;
      #1;
      chk("take+mret run", 64'({npc, stl[0]}), 64'd0);

      // reset mid-drain
      irq = 3'b010;
      @(negedge clk);
      #1;
      chk("drain before rst", 64'(stl[0]), 64'd1);
      rst = 1'b1; irq = 3'b000;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst drain run", 64'(stl[0]), 64'd0);
      @(negedge clk);
      #1;
      chk("rst drain no take", 64'(npc), 64'd0);
`else
      // without the IRQ feature interrupts are ignored
      @(negedge clk);
      irq = 3'b111; gen = 1'b1; ifv = 1'b1; ifpc = 32'h80; tcode = 4'h5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("noirq new_pc_en c%0d", i), 64'(npc), 64'd0);
         chk($sformatf("noirq is_trap c%0d", i), 64'(istrap), 64'd0);
         chk($sformatf("noirq stall c%0d", i), 64'(stl), 64'd0);
         chk($sformatf("noirq exc_pc c%0d", i), 64'(epc), 64'd0);
         chk($sformatf("noirq mcause c%0d", i), 64'(mcause), 64'h05);
      end
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
